mips_mc_core: RTL
=================

# mips_mc_core

Parametrised multi-cycle successor to the single-cycle `mips` top: a MIPS-I subset core that executes each instruction over several states and shares a single memory port between fetch and data, with wait-state support via a request/ready handshake. It replaces the separate instruction and data memories with one external memory interface. It adds illegal-instruction and misaligned-access trapping, plus a retire strobe for the verification scoreboard.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `ADDR_W`, default 32: width of `mem_addr`, taken from the low bits of the byte address; legal range 12..32.
- `clk` input, 1 bit: clock; all state updates occur on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `mem_req` output, 1 bit: memory access request.
- `mem_we` output, 1 bit: 1 = write (sw), 0 = read (fetch or lw).
- `mem_addr` output, `ADDR_W` bits: byte address, always word-aligned.
- `mem_wdata` output, 32 bits: store data.
- `mem_rdata` input, 32 bits: read data, valid in the cycle `mem_ready` is high.
- `mem_ready` input, 1 bit: access completes in any cycle where `mem_req && mem_ready`.
- `pc_o` output, 32 bits: PC of the instruction in flight.
- `retire` output, 1 bit: one-cycle pulse when an instruction commits.
- `halted` output, 1 bit: core is in TRAP.

## Operation
- Supported instructions:
  - R-type funct: addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, sll 0x00.
  - I-type: addiu 0x09 (sign-extended), ori 0x0D (zero-extended), lui 0x0F, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- State machine:
  - FETCH: `mem_req=1`, `mem_we=0`, `mem_addr=pc`. On ready, latch IR and go to DECODE.
  - DECODE: read rs/rt into the A/B latches and decode. An illegal opcode or funct goes to TRAP. Otherwise go to EXEC.
  - EXEC, ALU types: compute, then WB.
  - EXEC, lw/sw: compute address = rs + sext(imm). A misaligned address (low 2 bits ≠ 0) goes to TRAP. Otherwise go to MEM.
  - EXEC, beq: pc ← (A==B) ? pc+4+(sext(imm)<<2) : pc+4, retire, then FETCH.
  - EXEC, j: pc ← {pc+4[31:28], imm26, 2'b00}, retire, then FETCH.
  - MEM: hold req, addr, and we until ready. sw retires with pc+4 and returns to FETCH. lw latches MDR and goes to WB.
  - WB: write rd (R-type) or rt (I-type, lw), pc ← pc+4, retire, then FETCH.
  - TRAP: terminal. `halted=1`, `mem_req=0`; only reset exits.
- Register file is 32×32. Writes to $0 are discarded and $0 always reads 0.
- Arithmetic is 32-bit wraparound with no overflow exceptions. slt is a signed compare. sll shift amount is `shamt`.
- `mem_addr` drops the high bits of the byte address above `ADDR_W`.
- Reset values:
  - pc = `RESET_PC`; state = FETCH.
  - `mem_req=0` during reset; `mem_req` rises in the first cycle after deassertion.
  - `retire=0`, `halted=0`; all registers 0.
- Reset asserted mid-access abandons the access immediately. No write commits unless `mem_ready` was already sampled.

## Timing
- `mem_req` and its qualifiers stay stable from assertion until the ready cycle. The request is never withdrawn early.
- Zero-wait memory (ready tied high) gives these latencies:
  - R/I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Each wait cycle adds 1 cycle to the FETCH or MEM state it occurs in.
- `retire` pulses in the final state of each instruction. `pc_o` updates on the following edge.
- A register written in WB is visible to the next instruction's DECODE. No forwarding is needed.

## Structure
- Package `mips_mc_pkg` holds:
  - Opcode and funct localparams.
  - State enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - ALU-op enum.
- Sub-module `mc_alu`: combinational ALU taking the op enum, two 32-bit operands, and `shamt`; outputs result and zero.
- Register file, IR, MDR, and the A/B/ALUOut latches live inline in the core.

## Test plan
- Reset with `RESET_PC`=0x3000 and ready=1: first `mem_addr`=0x3000. ori $1,$0,0x1234 then addu $2,$1,$1 gives $2=0x2468 and `retire` pulses at cycles 4 and 8.
- lui $3,0x8000; ori $3,$3,1; sw $3,4($0); lw $4,4($0): the write carries addr 4 and data 0x8000_0001, $4=0x8000_0001, and the lw takes 5 cycles.
- Random 0–3 cycle ready stalls on fetch and MEM: `mem_req`/`mem_addr`/`mem_we` stay stable while stalled and final register state matches the zero-wait run.
- beq taken with offset −1 at 0x3010 gives next fetch at 0x3010. beq not taken gives 0x3014. j 0x0C00 from 0x3020 gives next fetch at 0x3000.
- Opcode 0x3F, or lw to address 0x2, gives `halted=1`, `mem_req` stays 0, and no retire pulse. Asserting `rst` low then restarts at `RESET_PC`.
- addiu $0,$0,5 then addu $5,$0,$0 gives $5=0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// ---------------------------------------------------------------------------
// mips_mc_pkg : opcodes, state/ALU enums and instruction decoder for mips_mc_core
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_LUI = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        logic    use_imm;
        logic    zext_imm;
        logic    is_lw;
        logic    is_sw;
        logic    is_beq;
        logic    is_j;
        logic    wr_rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d       = '0;
        d.op    = ALU_ADD;
        d.legal = 1'b1;
        unique case (ir[31:26])
            OP_RTYPE: begin
                d.wr_rd = 1'b1;
                unique case (ir[5:0])
                    FN_ADDU: d.op = ALU_ADD;
                    FN_SUBU: d.op = ALU_SUB;
                    FN_AND:  d.op = ALU_AND;
                    FN_OR:   d.op = ALU_OR;
                    FN_SLT:  d.op = ALU_SLT;
                    FN_SLL:  d.op = ALU_SLL;
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDIU: d.use_imm = 1'b1;
            OP_ORI: begin
                d.op       = ALU_OR;
                d.use_imm  = 1'b1;
                d.zext_imm = 1'b1;
            end
            OP_LUI: begin
                d.op       = ALU_LUI;
                d.use_imm  = 1'b1;
                d.zext_imm = 1'b1;
            end
            OP_LW: begin
                d.use_imm = 1'b1;
                d.is_lw   = 1'b1;
            end
            OP_SW: begin
                d.use_imm = 1'b1;
                d.is_sw   = 1'b1;
            end
            OP_BEQ: begin
                d.op     = ALU_SUB;
                d.is_beq = 1'b1;
            end
            OP_J:    d.is_j  = 1'b1;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_core_alu.sv
// ---------------------------------------------------------------------------
// mc_alu   : combinational ALU for mips_mc_core
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_alu
    import mips_mc_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLL: result_o = b_i << shamt_i;
            ALU_LUI: result_o = {b_i[15:0], 16'h0000};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'h0);

endmodule

`default_nettype wire

// File: rtl/mips_mc_core.sv
// ---------------------------------------------------------------------------
// mips_mc_core : multi-cycle MIPS-I subset core with one shared memory port
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_o,
    output logic              retire,
    output logic              halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] rf_q [32];

    dec_t        dec;
    logic [31:0] pc_plus4;
    logic [31:0] imm_sext;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic [31:0] addr_full;
    logic        rf_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    assign dec       = decode(ir_q);
    assign pc_plus4  = pc_q + 32'd4;
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign alu_b     = !dec.use_imm ? b_q :
                       (dec.zext_imm ? {16'h0000, ir_q[15:0]} : imm_sext);
    assign wb_addr   = dec.wr_rd ? ir_q[15:11] : ir_q[20:16];
    assign wb_data   = dec.is_lw ? mdr_q : alu_q;

    mc_alu u_alu (
        .op_i     (dec.op),
        .a_i      (a_q),
        .b_i      (alu_b),
        .shamt_i  (ir_q[10:6]),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = pc_q;
        retire    = 1'b0;
        rf_we     = 1'b0;
        unique case (state_q)
            FETCH: begin
                // Gated by rst so the port stays idle while reset is held.
                mem_req = rst;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = (ir_q[25:21] == 5'd0) ? 32'h0 : rf_q[ir_q[25:21]];
                b_d     = (ir_q[20:16] == 5'd0) ? 32'h0 : rf_q[ir_q[20:16]];
                state_d = dec.legal ? EXEC : TRAP;
            end
            EXEC: begin
                alu_d = alu_res;
                if (dec.is_lw || dec.is_sw) begin
                    state_d = (alu_res[1:0] != 2'b00) ? TRAP : MEM;
                end else if (dec.is_beq) begin
                    pc_d    = alu_zero ? br_target : pc_plus4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (dec.is_j) begin
                    pc_d    = j_target;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req   = rst;
                mem_we    = dec.is_sw;
                addr_full = alu_q;
                if (mem_ready) begin
                    if (dec.is_sw) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_d    = pc_plus4;
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign pc_o      = pc_q;
    assign halted    = (state_q == TRAP);

endmodule

`default_nettype wire
